// File: rtl/gnss_code_store.sv
// Multi-channel spreading-code store for the correlator array.
// Word a holds chip a of every channel (bit c = channel c). A round-robin
// read engine prefetches each channel's next chip into code_n_q. Each
// channel copies its prefetched chip into code_o on its own full_chip strobe.
module gnss_code_store #(
  parameter int CHANS   = 12,
  parameter int CODELEN = 4092,
  parameter int ABITS   = $clog2(CODELEN)
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   wr,
  input  logic [CHANS-1:0]       wdata,
  input  logic                   load_clr,
  output logic                   load_done,
  output logic                   load_ovf,
  input  logic [CHANS-1:0]       ch_en,
  input  logic [CHANS*ABITS-1:0] nchip,
  input  logic [CHANS-1:0]       full_chip,
  output logic [CHANS-1:0]       code_o
);

  // Memory index width; ABITS may be wider so callers can present
  // out-of-range chip indices.
  localparam int MBITS = $clog2(CODELEN);
  localparam int CBITS = $clog2(CHANS);

  typedef logic [ABITS-1:0] addr_t;
  typedef logic [MBITS-1:0] maddr_t;
  typedef logic [CBITS-1:0] slot_t;

  logic [CHANS-1:0] mem [CODELEN];

  addr_t            waddr_q, waddr_d;
  logic             load_done_q, load_done_d;
  logic             load_ovf_q, load_ovf_d;
  logic             we;

  slot_t            ch_p_q, ch_p_d;
  int               slot;
  addr_t            nchip_sel;
  maddr_t           raddr_q, raddr_d;
  logic [CHANS-1:0] rdata_q;
  logic [CHANS-1:0] code_n_q;
  logic [CHANS-1:0] code_o_q;

  // Load pointer: clear beats write; writes after completion only flag overflow.
  always_comb begin
    // NOTE: every output gets a default first so no path leaves it unassigned (no latch).
    waddr_d     = waddr_q;
    load_done_d = load_done_q;
    load_ovf_d  = load_ovf_q;
    we          = 1'b0;
    if (load_clr) begin
      waddr_d     = '0;
      load_done_d = 1'b0;
      load_ovf_d  = 1'b0;
    end else if (wr) begin
      if (load_done_q) begin
        load_ovf_d = 1'b1;
      end else begin
        we = 1'b1;
        if (waddr_q == addr_t'(CODELEN - 1)) begin
          waddr_d     = '0;
          load_done_d = 1'b1;
        end else begin
          waddr_d = waddr_q + addr_t'(1);
        end
      end
    end
  end

  // Load pointer and sticky status registers.
  always_ff @(posedge clk) begin
    // NOTE: state registers use non-blocking assignment so all flops update from pre-edge values.
    if (rst) begin
      waddr_q     <= '0;
      load_done_q <= 1'b0;
      load_ovf_q  <= 1'b0;
    end else begin
      waddr_q     <= waddr_d;
      load_done_q <= load_done_d;
      load_ovf_q  <= load_ovf_d;
    end
  end

  // Code memory write port.
  always_ff @(posedge clk) begin
    // NOTE: the array has no reset so it maps onto block RAM; load_done gates stale contents.
    if (we && !rst) begin
      mem[waddr_q[MBITS-1:0]] <= wdata;
    end
  end

  // Slot selection: serve the channel two ahead so its data lands when ch_p reaches it.
  always_comb begin
    ch_p_d = (ch_p_q == slot_t'(CHANS - 1)) ? '0 : ch_p_q + slot_t'(1);
    slot   = 32'(ch_p_q) + 2;
    if (slot >= CHANS) begin
      slot = slot - CHANS;
    end
    nchip_sel = nchip[slot*ABITS +: ABITS];
    raddr_d   = (32'(nchip_sel) >= CODELEN - 1) ? '0
                                                : maddr_t'(nchip_sel) + maddr_t'(1);
  end

  // Read pipeline: address register, registered read (read-first), prefetch update.
  always_ff @(posedge clk) begin
    if (rst) begin
      ch_p_q   <= '0;
      raddr_q  <= '0;
      rdata_q  <= '0;
      code_n_q <= '0;
    end else begin
      ch_p_q           <= ch_p_d;
      raddr_q          <= raddr_d;
      rdata_q          <= mem[raddr_q];
      code_n_q[ch_p_q] <= rdata_q[ch_p_q];
    end
  end

  // Per-channel output registers, each updating only on its own strobe.
  always_ff @(posedge clk) begin
    if (rst) begin
      code_o_q <= '0;
    end else begin
      for (int c = 0; c < CHANS; c++) begin
        if (full_chip[c]) begin
          code_o_q[c] <= ch_en[c] & load_done_q & code_n_q[c];
        end
      end
    end
  end

  assign load_done = load_done_q;
  assign load_ovf  = load_ovf_q;
  assign code_o    = code_o_q;

endmodule

// File: tb/tb_gnss_code_store.sv
// Bench for gnss_code_store: a 4-channel/8-chip build (ABITS=4 so that
// out-of-range indices can be driven) checked against an array model, and a
// 12-channel/4092-chip build used for scheduler latency and reset checks.
module tb_gnss_code_store;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  // Small build
  logic        rst = 1'b1, wr = 1'b0, load_clr = 1'b0;
  logic [3:0]  wdata = '0, ch_en = '0, full_chip = '0, code_o;
  logic [15:0] nchip = '0;
  logic        load_done, load_ovf;

  gnss_code_store #(.CHANS(4), .CODELEN(8), .ABITS(4)) dut (
    .clk(clk), .rst(rst), .wr(wr), .wdata(wdata), .load_clr(load_clr),
    .load_done(load_done), .load_ovf(load_ovf), .ch_en(ch_en),
    .nchip(nchip), .full_chip(full_chip), .code_o(code_o)
  );

  // Large build
  logic         rst12 = 1'b1, wr12 = 1'b0, load_clr12 = 1'b0;
  logic [11:0]  wdata12 = '0, ch_en12 = '0, full_chip12 = '0, code_o12;
  logic [143:0] nchip12 = '0;
  logic         load_done12, load_ovf12;

  gnss_code_store #(.CHANS(12), .CODELEN(4092)) dut12 (
    .clk(clk), .rst(rst12), .wr(wr12), .wdata(wdata12), .load_clr(load_clr12),
    .load_done(load_done12), .load_ovf(load_ovf12), .ch_en(ch_en12),
    .nchip(nchip12), .full_chip(full_chip12), .code_o(code_o12)
  );

  int total = 0;
  int bad   = 0;

  // Reference model of the small build
  bit [3:0] m_mem [8];
  int       m_waddr = 0;
  bit       m_done  = 0;
  bit       m_ovf   = 0;
  bit [3:0] m_code  = '0;

  function automatic int nxt(input int x);
    return (x >= 7) ? 0 : x + 1;
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic cmp(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic do_reset();
    rst = 1'b1;
    tick();
    rst = 1'b0;
    m_waddr = 0; m_done = 0; m_ovf = 0; m_code = '0;
  endtask

  task automatic do_write(input logic [3:0] w, input bit clr);
    wr = 1'b1; wdata = w; load_clr = clr;
    tick();
    wr = 1'b0; load_clr = 1'b0;
    if (clr) begin
      m_waddr = 0; m_done = 0; m_ovf = 0;
    end else if (m_done) begin
      m_ovf = 1;
    end else begin
      m_mem[m_waddr] = w;
      if (m_waddr == 7) begin m_waddr = 0; m_done = 1; end
      else m_waddr++;
    end
  endtask

  task automatic check_status(input string name);
    cmp({name, "_done"}, 32'(load_done), 32'(m_done));
    cmp({name, "_ovf"},  32'(load_ovf),  32'(m_ovf));
  endtask

  // Present chip indices, hold long enough for a full prefetch round, strobe.
  task automatic track(input string name, input logic [15:0] nc,
                       input logic [3:0] en, input logic [3:0] fc);
    nchip = nc; ch_en = en;
    repeat (6) tick();
    full_chip = fc;
    tick();
    full_chip = '0;
    for (int c = 0; c < 4; c++) begin
      if (fc[c]) m_code[c] = (en[c] && m_done) ? m_mem[nxt(int'(nc[c*4 +: 4]))][c] : 1'b0;
    end
    cmp(name, 32'(code_o), 32'(m_code));
  endtask

  task automatic load_list(input logic [31:0] words);
    for (int i = 0; i < 8; i++) do_write(words[i*4 +: 4], 1'b0);
  endtask

  task automatic test_reset();
    do_reset();
    cmp("reset_code_o", 32'(code_o), 32'h0);
    cmp("reset_done",   32'(load_done), 32'h0);
    cmp("reset_ovf",    32'(load_ovf), 32'h0);
    track("reset_strobe", 16'h0000, 4'hF, 4'hF);
    cmp("reset_strobe_zero", 32'(code_o), 32'h0);
  endtask

  task automatic test_load_track();
    // words 0..7 = 1,2,4,8,F,0,5,A (word 0 in the low nibble)
    for (int i = 0; i < 7; i++) do_write(4'(32'hA50F8421 >> (i*4)), 1'b0);
    cmp("load_done_after7", 32'(load_done), 32'h0);
    do_write(4'hA, 1'b0);
    cmp("load_done_after8", 32'(load_done), 32'h1);
    track("track_n3", 16'h3333, 4'hF, 4'hF);
    cmp("track_n3_literal", 32'(code_o), 32'hF);
  endtask

  task automatic test_wrap();
    track("n4_zero",   16'h3334, 4'hF, 4'h1);
    track("n7_wrap",   16'h3337, 4'hF, 4'h1);
    cmp("n7_wrap_bit0", 32'(code_o[0]), 32'h1);
    track("n4_again",  16'h3334, 4'hF, 4'h1);
    track("n9_oor",    16'h3339, 4'hF, 4'h1);
    cmp("n9_oor_bit0", 32'(code_o[0]), 32'h1);
  endtask

  task automatic test_ovf_clear();
    do_write(4'hE, 1'b0);
    check_status("ovf");
    cmp("ovf_literal", 32'(load_ovf), 32'h1);
    track("ovf_mem0_kept", 16'h3334, 4'hF, 4'h1);
    track("ovf_mem0_read", 16'h3337, 4'hF, 4'h1);
    do_write(4'h3, 1'b1);
    check_status("clr");
    cmp("clr_literal", 32'({load_done, load_ovf}), 32'h0);
    for (int i = 0; i < 7; i++) do_write(4'($urandom), 1'b0);
    cmp("reload_done_after7", 32'(load_done), 32'h0);
    do_write(4'($urandom), 1'b0);
    cmp("reload_done_after8", 32'(load_done), 32'h1);
    track("reload_track", 16'($urandom), 4'hF, 4'hF);
  endtask

  task automatic test_enable();
    do_write(4'h0, 1'b1);
    load_list(32'hA50F8421);
    track("en_all", 16'h3333, 4'hF, 4'hF);
    track("en_0101", 16'h6666, 4'b0101, 4'b0110);
    cmp("en_0101_literal", 32'(code_o), 32'b1001);
  endtask

  task automatic test_random();
    for (int it = 0; it < 30; it++) begin
      if ($urandom_range(0, 5) == 0) begin
        do_write(4'h0, 1'b1);
        for (int i = 0; i < int'($urandom_range(5, 10)); i++) do_write(4'($urandom), 1'b0);
        check_status("rand_load");
      end
      track("rand_track", 16'($urandom), 4'($urandom), 4'($urandom));
    end
  endtask

  task automatic test_sched12();
    bit seen;
    rst12 = 1'b1; tick(); rst12 = 1'b0;
    for (int a = 0; a < 4092; a++) begin
      wr12 = 1'b1;
      wdata12 = (a == 201) ? 12'hFFF : 12'h000;
      tick();
    end
    wr12 = 1'b0;
    cmp("s12_done", 32'(load_done12), 32'h1);
    nchip12[5*12 +: 12] = 12'd100;
    repeat (14) tick();
    cmp("s12_chip101", 32'(dut12.code_n_q[5]), 32'h0);
    nchip12[5*12 +: 12] = 12'd200;
    seen = 0;
    for (int i = 0; i < 14 && !seen; i++) begin
      tick();
      if (dut12.code_n_q[5] === 1'b1) seen = 1;
    end
    cmp("s12_chip201_within14", 32'(seen), 32'h1);
    repeat ($urandom_range(3, 9)) tick();
    rst12 = 1'b1; tick(); rst12 = 1'b0;
    cmp("s12_rst_ch_p", 32'(dut12.ch_p_q), 32'h0);
    cmp("s12_rst_done", 32'(load_done12), 32'h0);
    tick();
    cmp("s12_ch_p_next", 32'(dut12.ch_p_q), 32'h1);
  endtask

  initial begin
    rst12 = 1'b1;
    test_reset();
    test_load_track();
    test_wrap();
    test_ovf_clear();
    test_enable();
    test_random();
    test_sched12();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/gnss_code_store.md
Name: gnss_code_store

Overview:
- Parametrised multi-channel spreading-code memory for the GPS/Galileo correlator array; generalises the fixed 12-channel, 4092-chip E1B code store.
- Holds CODELEN words of CHANS bits. Bit c of word a is chip a of channel c's code.
- A time-multiplexed round-robin read engine prefetches each channel's next chip. Per-channel outputs update on that channel's full_chip strobe.
- Adds a load pointer with clear, load-complete/overflow status, per-channel enable, and registered (latch-free) outputs.

Parameters:
- CHANS, 12, number of channels; memory word width; must be >= 3.
- CODELEN, 4092, chips per code; must be >= 2.
- ABITS, clog2(CODELEN), width of address and nchip fields.

Ports:
- clk  in  1  clock
- rst  in  1  synchronous, active-high reset
- wr  in  1  write strobe; stores wdata at the load pointer
- wdata  in  CHANS  one chip for every channel
- load_clr  in  1  synchronous restart of loading
- load_done  out  1  sticky; CODELEN words have been written
- load_ovf  out  1  sticky; a write was attempted after load_done
- ch_en  in  CHANS  per-channel enable
- nchip  in  CHANS*ABITS  current chip index per channel; channel c occupies [c*ABITS +: ABITS]
- full_chip  in  CHANS  per-channel chip-boundary strobe
- code_o  out  CHANS  registered current chip per channel

Behaviour:
- Reset (rst=1 at posedge):
  - waddr=0, load_done=0, load_ovf=0, slot counter ch_p=0, all prefetch regs code_n=0, code_o=0.
  - Memory contents are not cleared.
  - rst overrides all other inputs.
- Load side:
  - If wr=1 and load_done=0: mem[waddr] <= wdata.
  - If waddr==CODELEN-1 at that write: waddr <= 0 and load_done <= 1. Otherwise waddr <= waddr+1.
  - If wr=1 and load_done=1: the write is discarded and load_ovf <= 1.
  - load_clr=1: waddr <= 0, load_done <= 0, load_ovf <= 0. When asserted together with wr, load_clr wins and the write is discarded.
- Read scheduler:
  - ch_p counts 0..CHANS-1 and wraps, advancing every cycle.
  - Channel-order note: the slot at cycle n serves channel k = (ch_p+2) mod CHANS.
  - Cycle n: nchip[k] is sampled and raddr <= next(nchip[k]).
  - next(x) = 0 if x >= CODELEN-1, else x+1. Out-of-range indices therefore wrap to 0.
  - Cycle n+1: BRAM registered read.
  - Cycle n+2 edge: code_n[k] <= mem[raddr] bit k.
  - Sample-to-code_n latency is 2 clocks. Every channel is refreshed exactly once per CHANS clocks.
  - Requirement on callers: nchip[c] must be stable for >= CHANS+2 clocks before full_chip[c] for code_o to reflect nchip[c]+1.
- Output:
  - At posedge with full_chip[c]=1: code_o[c] <= (ch_en[c] & load_done) ? code_n[c] : 0.
  - With full_chip[c]=0: code_o[c] holds.
  - Channels are independent. Simultaneous strobes on several channels all update in the same cycle.
- Read/write collision (same address, same cycle): the read returns old data (read-first).
  - Do not use the result unless load_done=1.
  - Callers must reload with load_clr before changing codes while tracking.
- A mid-load rst or load_clr leaves the partially written words in memory, but load_done=0 gates all outputs to 0.

Test Plan (CHANS=4, CODELEN=8 unless noted):
- Reset then idle:
  - Stimulus: reset, no further activity.
  - Required: code_o=0000, load_done=0, load_ovf=0. Pulsing full_chip=1111 keeps code_o=0000.
- Load and track:
  - Stimulus: write words 0x1,0x2,0x4,0x8,0xF,0x0,0x5,0xA. Then set ch_en=1111 and nchip[c]=3 for all c, hold 6 clocks, pulse full_chip=1111.
  - Required: load_done=1 after the 8th write, and code_o=1111 (word 4 = 0xF).
- Wrap and out-of-range:
  - Stimulus: same load, then nchip[0]=7, hold, strobe full_chip[0].
  - Required: code_o[0] = bit0 of word 0 = 1.
  - Stimulus: nchip[0]=9 (ABITS=4 build, CODELEN=8), hold, strobe.
  - Required: code_o[0] is again word-0 data (1).
- Overflow and clear:
  - Stimulus: a 9th wr after load_done.
  - Required: load_ovf=1 and mem[0] unchanged.
  - Stimulus: load_clr together with wr.
  - Required: load_done=0, load_ovf=0, waddr=0, write dropped.
- Enable and independence:
  - Stimulus: ch_en=0101, strobe only full_chip[1] and full_chip[2].
  - Required: code_o[1]=0 (disabled), code_o[2] updated, code_o[0] and code_o[3] held.
- Scheduler timing (CHANS=12, CODELEN=4092):
  - Stimulus: change nchip[5] from 100 to 200.
  - Required: code_n[5] reflects chip 201 no later than 14 clocks after the change.
  - Stimulus: rst asserted mid-schedule.
  - Required: ch_p=0 on the next cycle.
